// File: rtl/input_vc_ctrl.sv
// input_vc_ctrl: per-VC input FSMs, buffer occupancy, route latch and round-robin switch request.
// Define IVC_VA_STAGE_EN to insert the WAITING (output-VC allocation) stage between ROUTING and ACTIVE.
module input_vc_ctrl #(
    parameter  int NUM_VCS   = 2,
    parameter  int NUM_PORTS = 5,
    parameter  int BUF_DEPTH = 4,
    localparam int PW        = $clog2(NUM_PORTS) + 1,
    localparam int CW        = $clog2(BUF_DEPTH + 1),
    localparam int VW        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flit_valid,
    input  logic [VW-1:0]          i_flit_vc,
    input  logic [2*NUM_VCS-1:0]   i_front_type,
    input  logic [PW*NUM_VCS-1:0]  i_rc_port,
    input  logic [NUM_VCS-1:0]     i_va_gnt,
    input  logic                   i_sw_ack,
    output logic [2*NUM_VCS-1:0]   o_vc_state,
    output logic [PW*NUM_VCS-1:0]  o_vc_route,
    output logic [NUM_VCS-1:0]     o_va_req,
    output logic                   o_sw_req,
    output logic [VW-1:0]          o_sw_vc,
    output logic [PW-1:0]          o_sw_port,
    output logic                   o_pop,
    output logic [VW-1:0]          o_pop_vc,
    output logic                   o_credit_valid,
    output logic [VW-1:0]          o_credit_vc,
    output logic                   o_overflow
);
    typedef enum logic [1:0] {S_IDLE, S_ROUTING, S_WAITING, S_ACTIVE} state_t;
    localparam logic [PW-1:0] ROUTE_INV = PW'(1) << (PW - 1);
`ifdef IVC_VA_STAGE_EN
    localparam state_t S_ROUTED = S_WAITING;
`else
    localparam state_t S_ROUTED = S_ACTIVE;
    logic w_unused_gnt;
    assign w_unused_gnt = ^i_va_gnt;
`endif
    state_t              r_state [NUM_VCS];
    logic [CW-1:0]       r_occ   [NUM_VCS];
    logic [PW-1:0]       r_route [NUM_VCS];
    logic [VW-1:0]       r_ptr;
    logic [VW-1:0]       r_credit_vc;
    logic                r_credit_valid;
    logic                r_overflow;
    logic [NUM_VCS-1:0]  w_elig;
    logic [NUM_VCS-1:0]  w_wr;
    logic [NUM_VCS-1:0]  w_pop;
    logic                w_sw_req;
    logic [VW-1:0]       w_sw_vc;

    // Scan from the farthest offset down so the VC nearest the pointer wins.
    always_comb begin
        w_sw_req = 1'b0;
        w_sw_vc  = '0;
        for (int v = 0; v < NUM_VCS; v++)
            w_elig[v] = (r_state[v] == S_ACTIVE) && (r_occ[v] != '0);
        for (int k = NUM_VCS - 1; k >= 0; k--) begin
            if (w_elig[(int'(r_ptr) + k) % NUM_VCS]) begin
                w_sw_req = 1'b1;
                w_sw_vc  = VW'((int'(r_ptr) + k) % NUM_VCS);
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_wr[v]                  = i_flit_valid && (i_flit_vc == VW'(v));
            w_pop[v]                 = o_pop && (w_sw_vc == VW'(v));
            o_vc_state[2*v +: 2]     = r_state[v];
            o_vc_route[PW*v +: PW]   = r_route[v];
`ifdef IVC_VA_STAGE_EN
            o_va_req[v]              = r_state[v] == S_WAITING;
`else
            o_va_req[v]              = 1'b0;
`endif
        end
    end

    assign o_sw_req       = w_sw_req;
    assign o_sw_vc        = w_sw_vc;
    assign o_sw_port      = r_route[w_sw_vc];
    assign o_pop          = w_sw_req & i_sw_ack;
    assign o_pop_vc       = w_sw_vc;
    assign o_credit_valid = r_credit_valid;
    assign o_credit_vc    = r_credit_vc;
    assign o_overflow     = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_state[v] <= S_IDLE;
                r_occ[v]   <= '0;
                r_route[v] <= ROUTE_INV;
            end
            r_ptr          <= '0;
            r_credit_valid <= 1'b0;
            r_credit_vc    <= '0;
            r_overflow     <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_wr[v] && !w_pop[v]) begin
                    if (r_occ[v] == CW'(BUF_DEPTH))
                        r_overflow <= 1'b1;
                    else
                        r_occ[v] <= r_occ[v] + 1'b1;
                end else if (w_pop[v] && !w_wr[v]) begin
                    r_occ[v] <= r_occ[v] - 1'b1;
                end
                case (r_state[v])
                    S_IDLE: if (r_occ[v] != '0 && i_front_type[2*v+1]) r_state[v] <= S_ROUTING;
                    S_ROUTING: begin
                        r_route[v] <= i_rc_port[PW*v +: PW];
                        if (!i_rc_port[PW*v+PW-1]) r_state[v] <= S_ROUTED;
                    end
`ifdef IVC_VA_STAGE_EN
                    S_WAITING: if (i_va_gnt[v]) r_state[v] <= S_ACTIVE;
`endif
                    S_ACTIVE: if (w_pop[v] && i_front_type[2*v]) begin
                        r_state[v] <= S_IDLE;
                        r_route[v] <= ROUTE_INV;
                    end
                    default: ;
                endcase
            end
            if (o_pop) r_ptr <= (w_sw_vc == VW'(NUM_VCS - 1)) ? '0 : w_sw_vc + 1'b1;
            r_credit_valid <= o_pop;
            r_credit_vc    <= o_pop_vc;
        end
    end
endmodule

// File: tb/tb_input_vc_ctrl.sv
// tb_input_vc_ctrl: scenario tasks with a buffer model and a pop scoreboard for input_vc_ctrl.
module tb_input_vc_ctrl;
    localparam int NV = 2, NP = 5, BD = 4, PW = 4, VW = 1;
    localparam logic [PW-1:0] INV = 4'b1000;
`ifdef IVC_VA_STAGE_EN
    localparam bit VA = 1'b1;
`else
    localparam bit VA = 1'b0;
`endif
    typedef struct packed { logic [VW-1:0] vc; logic [PW-1:0] port; } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_flit_valid = 1'b0;
    logic [VW-1:0]     i_flit_vc = '0;
    logic [2*NV-1:0]   i_front_type = '0;
    logic [PW*NV-1:0]  i_rc_port = {NV{INV}};
    logic [NV-1:0]     i_va_gnt = '0;
    logic              i_sw_ack = 1'b0;
    logic [2*NV-1:0]   o_vc_state;
    logic [PW*NV-1:0]  o_vc_route;
    logic [NV-1:0]     o_va_req;
    logic              o_sw_req, o_pop, o_credit_valid, o_overflow;
    logic [VW-1:0]     o_sw_vc, o_pop_vc, o_credit_vc;
    logic [PW-1:0]     o_sw_port;

    int          total = 0, bad = 0;
    logic [1:0]  bq [NV][$];
    exp_t        exp_q[$];
    logic        obs_pop;
    logic [VW-1:0] obs_pop_vc;
    logic [PW-1:0] obs_sw_port;
    logic [1:0]  wr_type = 2'b00;

    input_vc_ctrl #(.NUM_VCS(NV), .NUM_PORTS(NP), .BUF_DEPTH(BD)) dut (
        .clk(clk), .reset(reset), .i_flit_valid(i_flit_valid), .i_flit_vc(i_flit_vc),
        .i_front_type(i_front_type), .i_rc_port(i_rc_port), .i_va_gnt(i_va_gnt), .i_sw_ack(i_sw_ack),
        .o_vc_state(o_vc_state), .o_vc_route(o_vc_route), .o_va_req(o_va_req), .o_sw_req(o_sw_req),
        .o_sw_vc(o_sw_vc), .o_sw_port(o_sw_port), .o_pop(o_pop), .o_pop_vc(o_pop_vc),
        .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // One clock: present the buffer-model front types, sample the switch outputs, update the model.
    task automatic cyc();
        for (int v = 0; v < NV; v++) i_front_type[2*v +: 2] = (bq[v].size() != 0) ? bq[v][0] : 2'b10;
        #1;
        obs_pop = o_pop;
        obs_pop_vc = o_pop_vc;
        obs_sw_port = o_sw_port;
        @(posedge clk);
        if (obs_pop) void'(bq[obs_pop_vc].pop_front());
        if (i_flit_valid && bq[i_flit_vc].size() < BD) bq[i_flit_vc].push_back(wr_type);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_flit_valid = 1'b0; i_flit_vc = '0; wr_type = 2'b00;
        i_va_gnt = '0; i_sw_ack = 1'b0; i_rc_port = {NV{INV}}; i_front_type = '0;
        for (int v = 0; v < NV; v++) bq[v].delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (o_vc_state !== '0) begin bad++; $display("FAIL rst_state got=%b want=0", o_vc_state); end
        if (o_vc_route !== {NV{INV}}) begin bad++; $display("FAIL rst_route got=%b want=%b", o_vc_route, {NV{INV}}); end
        if ({o_va_req, o_sw_req, o_pop} !== '0) begin bad++; $display("FAIL rst_req got=%b want=0", {o_va_req, o_sw_req, o_pop}); end
        if ({o_credit_valid, o_overflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {o_credit_valid, o_overflow}); end
    endtask

    task automatic test_head_tail();
        int seq[5];
        int n;
        logic exp_cv;
        exp_t e;
`ifdef IVC_VA_STAGE_EN
        seq = '{0, 1, 2, 3, 0}; n = 5;
`else
        seq = '{0, 1, 3, 0, 0}; n = 4;
`endif
        do_reset();
        i_rc_port = {INV, 4'b0001}; i_va_gnt = '1; i_sw_ack = 1'b1;
        exp_q.push_back('{vc: 1'b0, port: 4'b0001});
        i_flit_valid = 1'b1; i_flit_vc = 1'b0; wr_type = 2'b11;
        cyc();
        i_flit_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_cv = (k > 0) ? (seq[k-1] == 3) : 1'b0;
            total += 3;
            if (o_vc_state !== {2'b00, 2'(seq[k])}) begin bad++; $display("FAIL ht_state step=%0d got=%b want=%b", k, o_vc_state, {2'b00, 2'(seq[k])}); end
            if (o_va_req !== {1'b0, seq[k] == 2}) begin bad++; $display("FAIL ht_va_req step=%0d got=%b", k, o_va_req); end
            if ({o_credit_valid, o_credit_vc} !== {exp_cv, 1'b0}) begin bad++; $display("FAIL ht_credit step=%0d got=%b want=%b", k, {o_credit_valid, o_credit_vc}, {exp_cv, 1'b0}); end
            if (seq[k] == 3) begin
                total++;
                if (o_vc_route[PW-1:0] !== 4'b0001) begin bad++; $display("FAIL ht_route got=%b want=0001", o_vc_route[PW-1:0]); end
            end
            cyc();
            if (obs_pop) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ht_pop unexpected vc=%0d", obs_pop_vc);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_pop_vc, obs_sw_port} !== e) begin bad++; $display("FAIL ht_pop got=%b want=%b", {obs_pop_vc, obs_sw_port}, e); end
                end
            end
        end
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL ht_missing got=%0d want=0 pending", exp_q.size()); end
        if (o_vc_route[PW-1:0] !== INV) begin bad++; $display("FAIL ht_route_clr got=%b want=%b", o_vc_route[PW-1:0], INV); end
    endtask

    task automatic test_packet4();
        logic [1:0] t[4];
        int first, last, ncred;
        exp_t e;
        t = '{2'b10, 2'b00, 2'b00, 2'b01};
        first = -1; last = -1; ncred = 0;
        do_reset();
        i_rc_port = {4'b0010, INV}; i_va_gnt = '1; i_sw_ack = 1'b1; i_flit_vc = 1'b1;
        for (int c = 0; c < 16; c++) begin
            i_flit_valid = c < 4;
            wr_type = t[c < 4 ? c : 0];
            if (c < 4) exp_q.push_back('{vc: 1'b1, port: 4'b0010});
            cyc();
            if (obs_pop) begin
                total++;
                if (first < 0) first = c;
                last = c;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL p4_pop unexpected vc=%0d", obs_pop_vc);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_pop_vc, obs_sw_port} !== e) begin bad++; $display("FAIL p4_pop got=%b want=%b", {obs_pop_vc, obs_sw_port}, e); end
                end
            end
            if (o_credit_valid) begin
                ncred++; total++;
                if (o_credit_vc !== 1'b1) begin bad++; $display("FAIL p4_credit_vc got=%0d want=1", o_credit_vc); end
            end
        end
        total += 5;
        if (exp_q.size() != 0) begin bad++; $display("FAIL p4_missing got=%0d want=0 pending", exp_q.size()); end
        if (last - first != 3) begin bad++; $display("FAIL p4_consecutive got=%0d want=3", last - first); end
        if (ncred != 4) begin bad++; $display("FAIL p4_credits got=%0d want=4", ncred); end
        if (o_vc_state !== '0) begin bad++; $display("FAIL p4_idle got=%b want=0", o_vc_state); end
        if (o_vc_route !== {NV{INV}}) begin bad++; $display("FAIL p4_route_clr got=%b", o_vc_route); end
    endtask

    task automatic test_round_robin();
        logic [1:0] t[6];
        exp_t e;
        t = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        do_reset();
        i_rc_port = {4'b0011, 4'b0001}; i_va_gnt = '1; i_sw_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_flit_valid = c < 6;
            i_flit_vc = VW'(c % 2);
            wr_type = t[c < 6 ? c : 0];
            cyc();
        end
        i_flit_valid = 1'b0;
        total += 2;
        if (o_vc_state !== 4'b1111) begin bad++; $display("FAIL rr_active got=%b want=1111", o_vc_state); end
        if ({o_sw_req, o_sw_vc} !== 2'b10) begin bad++; $display("FAIL rr_first_req got=%b want=10", {o_sw_req, o_sw_vc}); end
        cyc();
        total++;
        if ({o_sw_req, o_sw_vc} !== 2'b10) begin bad++; $display("FAIL rr_hold got=%b want=10", {o_sw_req, o_sw_vc}); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{vc: 1'b0, port: 4'b0001});
            exp_q.push_back('{vc: 1'b1, port: 4'b0011});
        end
        i_sw_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (obs_pop) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rr_pop unexpected vc=%0d", obs_pop_vc);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_pop_vc, obs_sw_port} !== e) begin bad++; $display("FAIL rr_pop got=%b want=%b", {obs_pop_vc, obs_sw_port}, e); end
                end
            end
        end
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rr_missing got=%0d want=0 pending", exp_q.size()); end
        if (o_vc_state !== '0) begin bad++; $display("FAIL rr_idle got=%b want=0", o_vc_state); end
    endtask

    task automatic test_invalid_route();
        do_reset();
        i_rc_port = {INV, INV}; i_va_gnt = '0; i_sw_ack = 1'b0;
        i_flit_valid = 1'b1; i_flit_vc = 1'b0; wr_type = 2'b10;
        cyc();
        i_flit_valid = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            total += 2;
            if (o_vc_state[1:0] !== 2'b01) begin bad++; $display("FAIL ir_routing step=%0d got=%b want=01", k, o_vc_state[1:0]); end
            if ({o_va_req, o_vc_route[PW-1:0]} !== {2'b00, INV}) begin bad++; $display("FAIL ir_hold step=%0d got=%b", k, {o_va_req, o_vc_route[PW-1:0]}); end
            cyc();
        end
        i_rc_port = {INV, 4'b0001};
        cyc();
        total += 2;
        if (o_vc_state[1:0] !== (VA ? 2'b10 : 2'b11)) begin bad++; $display("FAIL ir_routed got=%b want=%b", o_vc_state[1:0], VA ? 2'b10 : 2'b11); end
        if ({o_va_req[0], o_vc_route[PW-1:0]} !== {VA, 4'b0001}) begin bad++; $display("FAIL ir_route got=%b want=%b", {o_va_req[0], o_vc_route[PW-1:0]}, {VA, 4'b0001}); end
`ifdef IVC_VA_STAGE_EN
        cyc();
        total++;
        if (o_vc_state[1:0] !== 2'b10) begin bad++; $display("FAIL ir_wait_nogrant got=%b want=10", o_vc_state[1:0]); end
        i_va_gnt = '1;
        cyc();
        total++;
        if (o_vc_state[1:0] !== 2'b11) begin bad++; $display("FAIL ir_granted got=%b want=11", o_vc_state[1:0]); end
`endif
    endtask

    task automatic test_overflow();
        logic [1:0] t[5];
        exp_t e;
        t = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        do_reset();
        i_rc_port = {INV, 4'b0001}; i_va_gnt = '1; i_sw_ack = 1'b0; i_flit_vc = 1'b0;
        for (int c = 0; c < 5; c++) begin
            i_flit_valid = 1'b1;
            wr_type = t[c];
            cyc();
            if (c == 3) begin
                total++;
                if (o_overflow !== 1'b0) begin bad++; $display("FAIL ov_at_full got=%b want=0", o_overflow); end
            end
        end
        total++;
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL ov_set got=%b want=1", o_overflow); end
        i_flit_valid = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        total += 2;
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b want=1", o_overflow); end
        if (o_vc_state[1:0] !== 2'b11) begin bad++; $display("FAIL ov_active got=%b want=11", o_vc_state[1:0]); end
        for (int i = 0; i < 5; i++) exp_q.push_back('{vc: 1'b0, port: 4'b0001});
        i_sw_ack = 1'b1;
        wr_type = 2'b01;
        for (int c = 0; c < 9; c++) begin
            i_flit_valid = c == 0;
            cyc();
            if (obs_pop) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ov_pop unexpected vc=%0d", obs_pop_vc);
                end else begin
                    e = exp_q.pop_front();
                    if ({obs_pop_vc, obs_sw_port} !== e) begin bad++; $display("FAIL ov_pop got=%b want=%b", {obs_pop_vc, obs_sw_port}, e); end
                end
            end
        end
        total += 3;
        if (exp_q.size() != 0) begin bad++; $display("FAIL ov_missing got=%0d want=0 pending", exp_q.size()); end
        if (o_vc_state !== '0) begin bad++; $display("FAIL ov_idle got=%b want=0", o_vc_state); end
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky_end got=%b want=1", o_overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_rc_port = {INV, 4'b0001}; i_va_gnt = '1; i_sw_ack = 1'b0; i_flit_vc = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_flit_valid = c < 2;
            wr_type = (c == 0) ? 2'b10 : 2'b00;
            cyc();
        end
        i_flit_valid = 1'b0;
        total++;
        if (o_vc_state[1:0] !== 2'b11) begin bad++; $display("FAIL rm_active got=%b want=11", o_vc_state[1:0]); end
        i_sw_ack = 1'b1;
        #1;
        total++;
        if (o_pop !== 1'b1) begin bad++; $display("FAIL rm_pending_pop got=%b want=1", o_pop); end
        reset = 1'b1;
        #1;
        total += 2;
        if ({o_vc_state, o_pop} !== '0) begin bad++; $display("FAIL rm_async got=%b want=0", {o_vc_state, o_pop}); end
        if (o_vc_route !== {NV{INV}}) begin bad++; $display("FAIL rm_route got=%b", o_vc_route); end
        for (int v = 0; v < NV; v++) bq[v].delete();
        @(posedge clk);
        @(negedge clk);
        total++;
        if (o_credit_valid !== 1'b0) begin bad++; $display("FAIL rm_credit got=%b want=0", o_credit_valid); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        total++;
        if ({o_vc_state, o_credit_valid} !== '0) begin bad++; $display("FAIL rm_occ_clr got=%b want=0", {o_vc_state, o_credit_valid}); end
    endtask

    initial begin
        test_reset();
        test_head_tail();
        test_packet4();
        test_round_robin();
        test_invalid_route();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
